// File: rtl/ofs_plat_prim_rsp_credit_arb.sv
// Round-robin arbiter for NUM_CH request streams that share one response-buffer credit pool.
// Each grant debits its beat count. Returned beats restore credits after RET_LATENCY stages.
module ofs_plat_prim_rsp_credit_arb #(
    parameter int unsigned NUM_CH             = 2,
    parameter int unsigned NUM_CREDITS        = 256,
    parameter int unsigned LEN_W              = 8,
    parameter int unsigned RET_W              = 1,
    parameter int unsigned RET_LATENCY        = 2,
    parameter int unsigned RESERVE_WORST_CASE = 0
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic [NUM_CH-1:0]                          req_valid,
    input  logic [NUM_CH*LEN_W-1:0]                    req_len,
    output logic [NUM_CH-1:0]                          req_ready,
    output logic                                       out_valid,
    output logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0] out_ch,
    output logic [LEN_W-1:0]                           out_len,
    input  logic                                       out_ready,
    input  logic                                       rsp_valid,
    input  logic [RET_W-1:0]                           rsp_cnt,
    output logic [$clog2(NUM_CREDITS+1)-1:0]           credits,
    output logic                                       err_overflow
);

    localparam int unsigned CHW = $clog2(NUM_CH > 1 ? NUM_CH : 2);
    localparam int unsigned CW  = $clog2(NUM_CREDITS + 1);
    localparam logic [LEN_W:0] NEED_WC = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0] ONE_N   = (LEN_W+1)'(1);

    logic [CHW-1:0]    ptr;
    logic              slot_free;
    logic [LEN_W:0]    need [NUM_CH];
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] grant;
    logic              grant_any;
    logic [CHW-1:0]    grant_ch;
    logic [CHW-1:0]    idx;
    logic [LEN_W-1:0]  grant_len;
    logic [LEN_W:0]    debit;
    logic [RET_W-1:0]  ret;
    logic [RET_W-1:0]  ret_q;
    logic [CW:0]       cred_sum;
    logic              overflow;

    // Eligibility uses the registered credit count; there is no bypass from this cycle's update.
    always_comb begin
        slot_free = !out_valid || out_ready;
        eligible  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            need[i]     = (RESERVE_WORST_CASE != 0) ? NEED_WC
                                                    : {1'b0, req_len[i*LEN_W +: LEN_W]} + ONE_N;
            eligible[i] = req_valid[i] && slot_free && (credits >= CW'(need[i]));
        end
    end

    always_comb begin
        grant_any = 1'b0;
        grant_ch  = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = CHW'((32'(ptr) + k) % NUM_CH);
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_ch  = idx;
            end
        end
    end

    assign grant     = grant_any ? (NUM_CH'(1) << grant_ch) : '0;
    assign req_ready = reset_n ? grant : '0;
    assign grant_len = req_len[grant_ch*LEN_W +: LEN_W];
    assign debit     = grant_any ? ({1'b0, grant_len} + ONE_N) : '0;
    assign ret       = rsp_valid ? rsp_cnt : '0;

    if (RET_LATENCY == 0) begin : g_ret_direct
        assign ret_q = ret;
    end else begin : g_ret_pipe
        logic [RET_W-1:0] pipe [RET_LATENCY];
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int unsigned i = 0; i < RET_LATENCY; i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= ret;
                for (int unsigned i = 1; i < RET_LATENCY; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign ret_q = pipe[RET_LATENCY-1];
    end

    // The debit never exceeds credits, so one extra bit is enough to see overflow from returns.
    assign cred_sum = {1'b0, credits} - (CW+1)'(debit) + (CW+1)'(ret_q);
    assign overflow = cred_sum > (CW+1)'(NUM_CREDITS);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            out_ch       <= '0;
            out_len      <= '0;
            credits      <= CW'(NUM_CREDITS);
            err_overflow <= 1'b0;
            ptr          <= '0;
        end else begin
            if (grant_any) begin
                out_valid <= 1'b1;
                out_ch    <= grant_ch;
                out_len   <= grant_len;
                ptr       <= (grant_ch == CHW'(NUM_CH-1)) ? '0 : grant_ch + CHW'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (overflow) begin
                credits      <= CW'(NUM_CREDITS);
                err_overflow <= 1'b1;
            end else begin
                credits <= cred_sum[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert ($onehot0(req_ready));
            assert ({1'b0, credits} <= (CW+1)'(NUM_CREDITS));
        end
    end

endmodule
